multicycle_controller: RTL

- Next-generation main control unit for the MIPS-lite core. It replaces the single-cycle opcode decoder with a multi-cycle FSM.
- Sequences every instruction through FETCH/DECODE/EXEC/MEM/WB, with ready/valid-style waits on instruction and data memory.
- Opcode latched in DECODE; per-state control strobes drive the shared datapath (PC, IR, register file, ALU, memory muxes).
- ALU-op width and opcode encodings are parametrised.

---
 rtl/multicycle_controller.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS-lite control FSM (FETCH/DECODE/EXEC/MEM/WB)
// Optional cycle/retire counters under MULTICYCLE_PERF_CNT_EN.
module multicycle_controller #(
  parameter int          ALU_OP_LENGTH = 3,
  parameter logic [5:0]  OP_R_TYPE     = 6'b000000,
  parameter logic [5:0]  OP_ORI        = 6'b001101,
  parameter logic [5:0]  OP_XORI       = 6'b001110,
  parameter logic [5:0]  OP_LW         = 6'b100011,
  parameter logic [5:0]  OP_SW         = 6'b101011,
  parameter logic [5:0]  OP_BEQ        = 6'b000100,
  parameter logic [5:0]  OP_JAL        = 6'b000011
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               op,
  input  logic                     imem_ready,
  input  logic                     dmem_ready,
  output logic                     imem_req,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic                     dmem_req,
  output logic                     MemWrite,
  output logic                     RegDst,
  output logic                     Branch,
  output logic                     Jmp,
  output logic                     Write_reg_mux,
  output logic                     ALUsrc,
  output logic                     extend_op,
  output logic                     RegWrite,
  output logic [ALU_OP_LENGTH-1:0] alu_op,
  output logic [2:0]               state,
  output logic                     illegal_op
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [31:0]              cycle_cnt,
  output logic [31:0]              retire_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_ORI, C_XORI, C_LW, C_SW, C_BEQ, C_JAL, C_ILL
  } iclass_t;

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;
  iclass_t    cls_in;
  iclass_t    cls_q;

  logic [2:0] alu3;
  logic       sel_regdst;
  logic       sel_alusrc;
  logic       sel_ext;
  logic       sel_wrm;
  logic [2:0] sel_alu;

  // First matching parameter wins if two opcodes are configured identically.
  function automatic iclass_t classify(input logic [5:0] o);
    if (o == OP_R_TYPE)     return C_R;
    else if (o == OP_ORI)   return C_ORI;
    else if (o == OP_XORI)  return C_XORI;
    else if (o == OP_LW)    return C_LW;
    else if (o == OP_SW)    return C_SW;
    else if (o == OP_BEQ)   return C_BEQ;
    else if (o == OP_JAL)   return C_JAL;
    else                    return C_ILL;
  endfunction

  assign cls_in = classify(op);
  assign cls_q  = classify(op_q);
  assign state  = state_q;
  assign alu_op = ALU_OP_LENGTH'(alu3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= op;
      end
    end
  end

  // Datapath mux selects derived from the latched opcode; held EXEC through WB.
  always_comb begin
    sel_regdst = 1'b0;
    sel_alusrc = 1'b0;
    sel_ext    = 1'b0;
    sel_wrm    = 1'b0;
    sel_alu    = 3'b000;
    case (cls_q)
      C_R:    begin sel_alu = 3'b011; sel_regdst = 1'b1; end
      C_ORI:  begin sel_alu = 3'b010; sel_alusrc = 1'b1; end
      C_XORI: begin sel_alu = 3'b100; sel_alusrc = 1'b1; end
      C_LW:   begin sel_alu = 3'b000; sel_alusrc = 1'b1; sel_ext = 1'b1; sel_wrm = 1'b1; end
      C_SW:   begin sel_alu = 3'b000; sel_alusrc = 1'b1; sel_ext = 1'b1; end
      C_BEQ:  begin sel_alu = 3'b001; end
      default: begin end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    dmem_req      = 1'b0;
    MemWrite      = 1'b0;
    RegDst        = 1'b0;
    Branch        = 1'b0;
    Jmp           = 1'b0;
    Write_reg_mux = 1'b0;
    ALUsrc        = 1'b0;
    extend_op     = 1'b0;
    RegWrite      = 1'b0;
    illegal_op    = 1'b0;
    alu3          = 3'b000;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        case (cls_in)
          C_ILL: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
          C_JAL:   state_d = S_WB;
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        alu3      = sel_alu;
        ALUsrc    = sel_alusrc;
        extend_op = sel_ext;
        RegDst    = sel_regdst;
        Write_reg_mux = sel_wrm;
        case (cls_q)
          C_BEQ: begin
            Branch  = 1'b1;
            state_d = S_FETCH;
          end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end

      S_MEM: begin
        alu3          = sel_alu;
        ALUsrc        = sel_alusrc;
        extend_op     = sel_ext;
        RegDst        = sel_regdst;
        Write_reg_mux = sel_wrm;
        dmem_req      = 1'b1;
        MemWrite      = (cls_q == C_SW);
        if (dmem_ready) begin
          state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
        end
      end

      S_WB: begin
        alu3          = sel_alu;
        ALUsrc        = sel_alusrc;
        extend_op     = sel_ext;
        RegDst        = sel_regdst;
        Write_reg_mux = sel_wrm;
        Jmp           = (cls_q == C_JAL);
        RegWrite      = 1'b1;
        state_d       = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    // Outputs are forced quiet for the whole time reset is held.
    if (rst) begin
      imem_req      = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      dmem_req      = 1'b0;
      MemWrite      = 1'b0;
      RegDst        = 1'b0;
      Branch        = 1'b0;
      Jmp           = 1'b0;
      Write_reg_mux = 1'b0;
      ALUsrc        = 1'b0;
      extend_op     = 1'b0;
      RegWrite      = 1'b0;
      illegal_op    = 1'b0;
      alu3          = 3'b000;
    end
  end

`ifdef MULTICYCLE_PERF_CNT_EN
  logic retire_evt;

  // Retire = leaving EXEC/MEM/WB back to FETCH; illegal ops leave from DECODE.
  assign retire_evt = (state_d == S_FETCH) &&
                      ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire_evt) begin
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
